// File: rtl/trx_mode_sequencer_pkg.sv
// Mode and FSM encodings shared by the T/R mode sequencer.
// Optional CW radar mode (11) is enabled by defining TRX_CW_MODE_EN.
package trx_pkg;

    localparam logic [1:0] MODE_STBY = 2'b00;
    localparam logic [1:0] MODE_RX   = 2'b01;
    localparam logic [1:0] MODE_TX   = 2'b10;
    localparam logic [1:0] MODE_CW   = 2'b11;

    typedef enum logic [1:0] {
        ST_STBY   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

`ifdef TRX_CW_MODE_EN
    localparam bit CW_EN = 1'b1;
`else
    localparam bit CW_EN = 1'b0;
`endif

    // CW (BS1 TX / BS2 RX) is only a legal request when the build enables it
    function automatic logic mode_legal(input logic [1:0] mode);
        return CW_EN || (mode != MODE_CW);
    endfunction

endpackage

// File: rtl/trx_mode_sequencer_if.sv
// Host command handshake into the T/R mode sequencer.
interface trx_mode_sequencer_if;
    logic       i_cmd_valid;
    logic [1:0] i_cmd_mode;
    logic       o_cmd_ready;

    modport master (output i_cmd_valid, output i_cmd_mode, input  o_cmd_ready);
    modport slave  (input  i_cmd_valid, input  i_cmd_mode, output o_cmd_ready);
endinterface

// File: rtl/trx_mode_sequencer_tx_limiter.sv
// Continuous-transmit duration counter; trip marks the edge on which TX must drop.
module trx_tx_limiter #(
    parameter int unsigned MAX_TX_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_on,
    input  logic clear,
    output logic trip
);

    localparam int unsigned TXC_W = (MAX_TX_CYC > 0) ? $clog2(MAX_TX_CYC + 1) : 1;

    generate
        if (MAX_TX_CYC == 0) begin : g_off
            assign trip = 1'b0;
        end else begin : g_on
            logic [TXC_W-1:0] cnt_q;
            logic [TXC_W-1:0] cnt_d;

            // Saturating so a command that overrides a trip cannot wrap the count
            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (tx_on && (cnt_q != TXC_W'(MAX_TX_CYC))) begin
                    cnt_d = cnt_q + TXC_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            // Count holds completed TX cycles, so this edge ends cycle MAX_TX_CYC
            assign trip = tx_on && (cnt_q >= TXC_W'(MAX_TX_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/trx_mode_sequencer.sv
// Module_TX/Module_RX mode sequencer with standby guard and PA transmit-time limit.
// Defining TRX_CW_MODE_EN makes mode 11 (CW radar) a legal command.
module trx_mode_sequencer
    import trx_pkg::*;
#(
    parameter int unsigned GUARD_CYC  = 16,
    parameter int unsigned MAX_TX_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    trx_mode_sequencer_if.slave  cmd,
    output logic                 o_Module_TX,
    output logic                 o_Module_RX,
    output logic                 o_busy,
    output logic [1:0]           o_cur_mode,
    output logic                 o_tx_timeout,
    output logic                 o_cmd_err
);

    localparam int unsigned GW = $clog2(GUARD_CYC + 1);

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [1:0]     target_q, target_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic           timeout_q, timeout_d;
    logic           err_q, err_d;
    logic           ready_q, busy_q;
    logic           accept_c, tx_clr_c, trip;

    assign accept_c = cmd.i_cmd_valid && ready_q;
    assign tx_clr_c = mode_d[1] && !mode_q[1];

    trx_tx_limiter #(.MAX_TX_CYC(MAX_TX_CYC)) u_tx_limiter (
        .clk   (clk),
        .rst   (rst),
        .tx_on (mode_q[1]),
        .clear (tx_clr_c),
        .trip  (trip)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        target_d  = target_q;
        gcnt_d    = gcnt_q;
        timeout_d = timeout_q;
        err_d     = 1'b0;
        case (state_q)
            ST_GUARD: begin
                if (gcnt_q == GW'(GUARD_CYC - 1)) begin
                    state_d = ST_ACTIVE;
                    mode_d  = target_q;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                // A legal command on the trip edge wins over the timeout
                if (accept_c && mode_legal(cmd.i_cmd_mode)) begin
                    timeout_d = 1'b0;
                    if (cmd.i_cmd_mode != mode_q) begin
                        mode_d = MODE_STBY;
                        if (cmd.i_cmd_mode == MODE_STBY) begin
                            state_d = ST_STBY;
                        end else begin
                            state_d  = ST_GUARD;
                            target_d = cmd.i_cmd_mode;
                            gcnt_d   = '0;
                        end
                    end
                end else begin
                    err_d = accept_c;
                    if (trip) begin
                        state_d   = ST_STBY;
                        mode_d    = MODE_STBY;
                        timeout_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STBY;
            mode_q    <= MODE_STBY;
            target_q  <= MODE_STBY;
            gcnt_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            target_q  <= target_d;
            gcnt_q    <= gcnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            ready_q   <= (state_d != ST_GUARD);
            busy_q    <= (state_d == ST_GUARD);
        end
    end

    assign cmd.o_cmd_ready = ready_q;
    assign o_Module_TX     = mode_q[1];
    assign o_Module_RX     = mode_q[0];
    assign o_cur_mode      = mode_q;
    assign o_busy          = busy_q;
    assign o_tx_timeout    = timeout_q;
    assign o_cmd_err       = err_q;

endmodule

// File: tb/tb_trx_mode_sequencer.sv
// Directed bench for trx_mode_sequencer (GUARD_CYC=16, MAX_TX_CYC=50).
module tb_trx_mode_sequencer;

    localparam int unsigned GUARD = 16;
    localparam int unsigned MAXTX = 50;

    // Observation vector: {TX, RX, cur_mode[1:0], ready, busy, timeout, err}
    localparam logic [7:0] V_IDLE    = 8'b0000_1000;
    localparam logic [7:0] V_GUARD   = 8'b0000_0100;
    localparam logic [7:0] V_TX      = 8'b1010_1000;
    localparam logic [7:0] V_RX      = 8'b0101_1000;
    localparam logic [7:0] V_TMO     = 8'b0000_1010;
    localparam logic [7:0] V_RX_ERR  = 8'b0101_1001;
    localparam logic [7:0] V_CW      = 8'b1111_1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx, rx, busy, tmo, err;
    logic [1:0] cur;
    int         checks = 0;
    int         errors = 0;

    trx_mode_sequencer_if cmd_if();

    trx_mode_sequencer #(.GUARD_CYC(GUARD), .MAX_TX_CYC(MAXTX)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if.slave),
        .o_Module_TX  (tx),
        .o_Module_RX  (rx),
        .o_busy       (busy),
        .o_cur_mode   (cur),
        .o_tx_timeout (tmo),
        .o_cmd_err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {tx, rx, cur, cmd_if.o_cmd_ready, busy, tmo, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a command until the handshake completes; returns #1 after the accept edge
    task automatic send(input logic [1:0] m, output bit ok);
        int n;
        bit acc;
        n  = 0;
        ok = 1'b0;
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd_mode  = m;
        while (!ok && n < 100) begin
            acc = cmd_if.o_cmd_ready;
            step();
            ok = acc;
            n++;
        end
        cmd_if.i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd_mode  = 2'b00;
        step(); step();
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL reset_held got %b exp %b", obs(), V_IDLE);
        end
        #2 rst = 1'b0;
        step();
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL reset_release got %b exp %b", obs(), V_IDLE);
        end
    endtask

    task automatic test_guard_tx_limit();
        bit ok;
        int n;
        send(2'b10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gtx_accept got 0 exp 1"); end
        checks++;
        if (obs() !== V_GUARD) begin
            errors++; $display("FAIL gtx_accept_edge got %b exp %b", obs(), V_GUARD);
        end
        for (int k = 1; k < GUARD; k++) begin
            step();
            checks++;
            if (obs() !== V_GUARD) begin
                errors++; $display("FAIL gtx_guard cyc %0d got %b exp %b", k, obs(), V_GUARD);
            end
        end
        step();
        checks++;
        if (obs() !== V_TX) begin
            errors++; $display("FAIL gtx_active got %b exp %b", obs(), V_TX);
        end
        n = 0;
        while (tx === 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 50) begin errors++; $display("FAIL tx_high_cycles got %0d exp 50", n); end
        checks++;
        if (obs() !== V_TMO) begin
            errors++; $display("FAIL tx_timeout got %b exp %b", obs(), V_TMO);
        end
    endtask

    task automatic test_timeout_clear();
        bit ok;
        send(2'b01, ok);
        checks++;
        if (!ok || obs() !== V_GUARD) begin
            errors++; $display("FAIL tmo_clear got %b ok %0d exp %b", obs(), ok, V_GUARD);
        end
        for (int k = 0; k < GUARD; k++) step();
        checks++;
        if (obs() !== V_RX) begin
            errors++; $display("FAIL rx_active got %b exp %b", obs(), V_RX);
        end
    endtask

    task automatic test_rx_to_tx_hold();
        bit ok;
        send(2'b10, ok);
        checks++;
        if (!ok || obs() !== V_GUARD) begin
            errors++; $display("FAIL rx2tx_accept got %b ok %0d exp %b", obs(), ok, V_GUARD);
        end
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd_mode  = 2'b00;
        for (int k = 1; k < GUARD; k++) begin
            step();
            checks++;
            if (obs() !== V_GUARD) begin
                errors++; $display("FAIL rx2tx_guard cyc %0d got %b exp %b", k, obs(), V_GUARD);
            end
        end
        step();
        checks++;
        if (obs() !== V_TX) begin
            errors++; $display("FAIL rx2tx_active got %b exp %b", obs(), V_TX);
        end
        step();
        cmd_if.i_cmd_valid = 1'b0;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL held_stby got %b exp %b", obs(), V_IDLE);
        end
    endtask

    task automatic test_same_mode();
        bit ok;
        int n;
        send(2'b10, ok);
        for (int k = 0; k < GUARD; k++) step();
        checks++;
        if (!ok || obs() !== V_TX) begin
            errors++; $display("FAIL same_enter got %b ok %0d exp %b", obs(), ok, V_TX);
        end
        for (int k = 0; k < 29; k++) step();
        send(2'b10, ok);
        checks++;
        if (!ok || obs() !== V_TX) begin
            errors++; $display("FAIL same_no_guard got %b ok %0d exp %b", obs(), ok, V_TX);
        end
        n = 0;
        while (tx === 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 20) begin errors++; $display("FAIL same_remaining got %0d exp 20", n); end
        checks++;
        if (obs() !== V_TMO) begin
            errors++; $display("FAIL same_timeout got %b exp %b", obs(), V_TMO);
        end
    endtask

    task automatic test_cmd_cw();
        bit ok;
        send(2'b01, ok);
        for (int k = 0; k < GUARD; k++) step();
        checks++;
        if (!ok || obs() !== V_RX) begin
            errors++; $display("FAIL cw_pre_rx got %b ok %0d exp %b", obs(), ok, V_RX);
        end
        send(2'b11, ok);
`ifdef TRX_CW_MODE_EN
        checks++;
        if (!ok || obs() !== V_GUARD) begin
            errors++; $display("FAIL cw_guard got %b ok %0d exp %b", obs(), ok, V_GUARD);
        end
        for (int k = 1; k < GUARD; k++) step();
        checks++;
        if (obs() !== V_GUARD) begin
            errors++; $display("FAIL cw_guard_end got %b exp %b", obs(), V_GUARD);
        end
        step();
        checks++;
        if (obs() !== V_CW) begin
            errors++; $display("FAIL cw_active got %b exp %b", obs(), V_CW);
        end
`else
        checks++;
        if (!ok || obs() !== V_RX_ERR) begin
            errors++; $display("FAIL cw_reject got %b ok %0d exp %b", obs(), ok, V_RX_ERR);
        end
        step();
        checks++;
        if (obs() !== V_RX) begin
            errors++; $display("FAIL cw_err_pulse got %b exp %b", obs(), V_RX);
        end
`endif
    endtask

    task automatic test_async_reset();
        bit ok;
        send(2'b10, ok);
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (!ok || obs() !== V_GUARD) begin
            errors++; $display("FAIL ar_pre_guard got %b ok %0d exp %b", obs(), ok, V_GUARD);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL ar_mid_guard got %b exp %b", obs(), V_IDLE);
        end
        #2 rst = 1'b0;
        step();
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL ar_guard_release got %b exp %b", obs(), V_IDLE);
        end
        send(2'b10, ok);
        for (int k = 0; k < GUARD + 10; k++) step();
        checks++;
        if (!ok || obs() !== V_TX) begin
            errors++; $display("FAIL ar_pre_tx got %b ok %0d exp %b", obs(), ok, V_TX);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL ar_mid_tx got %b exp %b", obs(), V_IDLE);
        end
        #2 rst = 1'b0;
        step();
        checks++;
        if (obs() !== V_IDLE) begin
            errors++; $display("FAIL ar_tx_release got %b exp %b", obs(), V_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_guard_tx_limit();
        test_timeout_clear();
        test_rx_to_tx_hold();
        test_same_mode();
        test_cmd_cw();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
